// File: rtl/vga_text_writer.sv
// vga_text_writer: write-side companion to the text-mode pixel generator.
// Takes character codes over a valid/ready handshake and writes
// {attr, glyph} cell words into VGA memory at a hardware cursor.
// Handles newline, carriage return, backspace and form feed (screen clear).
// Optional feature macro: CLEAR_LINE_EN -- when defined, every row change
// caused by newline or printable wrap blanks the newly entered row.
module vga_text_writer #(
   parameter logic [14:0] BASE_ADDR  = 15'd0,
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 60,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   input  logic [7:0]  char_attr,
   output logic        char_ready,
   output logic        busy,
   output logic [6:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata
);

   localparam int unsigned CNT_W = $clog2(COLS * ROWS);
   localparam logic [CNT_W-1:0] LAST_SCR  = CNT_W'(COLS * ROWS - 1);
`ifdef CLEAR_LINE_EN
   localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(COLS - 1);
`endif
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
`ifdef CLEAR_LINE_EN
      CLR_LINE,
`endif
      CLR_SCREEN
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       col_q, col_d;
   logic [5:0]       row_q, row_d;
   logic             we_q, we_d;
   logic [14:0]      addr_q, addr_d;
   logic [15:0]      wdata_q, wdata_d;
   logic             busy_q, busy_d;
   logic [7:0]       attr_q, attr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [14:0]      base_q, base_d;
   logic [5:0]       next_row;

   // Cell address: full-width sum, then wrapped into the 15-bit word space.
   function automatic logic [14:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
      return 15'(32'(BASE_ADDR) + 32'(row) * COLS + 32'(col));
   endfunction

   // Offset from a clear region's first cell, wrapped the same way.
   function automatic logic [14:0] region_addr(input logic [14:0] base, input logic [CNT_W-1:0] off);
      return 15'(32'(base) + 32'(off));
   endfunction

   assign next_row   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
   assign char_ready = (state_q == IDLE) && !reset;
   assign busy       = busy_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

   // Next-state, cursor and write-port decode; write strobe defaults low.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      attr_d  = attr_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (char_valid) begin
               unique case (char_data)
                  8'h0A: begin
                     col_d = 7'd0;
                     row_d = next_row;
`ifdef CLEAR_LINE_EN
                     state_d = CLR_LINE;
                     busy_d  = 1'b1;
                     attr_d  = char_attr;
                     cnt_d   = '0;
                     base_d  = cell_addr(next_row, 7'd0);
`endif
                  end
                  8'h0D: col_d = 7'd0;
                  8'h08: begin
                     // Backspace at column 0 is a no-op.
                     if (col_q != 7'd0) begin
                        col_d   = col_q - 7'd1;
                        we_d    = 1'b1;
                        addr_d  = cell_addr(row_q, col_q - 7'd1);
                        wdata_d = {char_attr, BLANK_CHAR};
                     end
                  end
                  8'h0C: begin
                     // First blank goes out with the acceptance itself so the
                     // clear occupies exactly COLS*ROWS cycles.
                     state_d = CLR_SCREEN;
                     busy_d  = 1'b1;
                     col_d   = 7'd0;
                     row_d   = 6'd0;
                     attr_d  = char_attr;
                     cnt_d   = '0;
                     base_d  = BASE_ADDR;
                     we_d    = 1'b1;
                     addr_d  = BASE_ADDR;
                     wdata_d = {char_attr, BLANK_CHAR};
                  end
                  default: begin
                     we_d    = 1'b1;
                     addr_d  = cell_addr(row_q, col_q);
                     wdata_d = {char_attr, char_data};
                     if (col_q == LAST_COL) begin
                        col_d = 7'd0;
                        row_d = next_row;
`ifdef CLEAR_LINE_EN
                        state_d = CLR_LINE;
                        busy_d  = 1'b1;
                        attr_d  = char_attr;
                        cnt_d   = '0;
                        base_d  = cell_addr(next_row, 7'd0);
`endif
                     end else begin
                        col_d = col_q + 7'd1;
                     end
                  end
               endcase
            end
         end
         CLR_SCREEN: begin
            if (cnt_q == LAST_SCR) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               we_d    = 1'b1;
               addr_d  = region_addr(base_q, cnt_q + CNT_W'(1));
               wdata_d = {attr_q, BLANK_CHAR};
            end
         end
`ifdef CLEAR_LINE_EN
         CLR_LINE: begin
            // The row-changing printable may still own the write port in the
            // first cycle here, so line blanks start one edge later.
            we_d    = 1'b1;
            addr_d  = region_addr(base_q, cnt_q);
            wdata_d = {attr_q, BLANK_CHAR};
            if (cnt_q == LAST_LINE) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State, cursor and registered write port; reset abandons any clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         col_q   <= 7'd0;
         row_q   <= 6'd0;
         we_q    <= 1'b0;
         addr_q  <= 15'd0;
         wdata_q <= 16'd0;
         busy_q  <= 1'b0;
         attr_q  <= 8'd0;
         cnt_q   <= '0;
         base_q  <= 15'd0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         attr_q  <= attr_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer in its default build.
module tb_vga_text_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic [7:0]  char_attr = 8'h00;
   logic        char_ready;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata;

   int          n_chk = 0;
   int          n_fail = 0;

   // Write monitor state (written only by the monitor process).
   int          wr_total = 0;
   int          seq_err = 0;
   // Monitor controls (written only by the stimulus process).
   bit          seq_en = 1'b0;
   int          seq_base = 0;
   logic [15:0] seq_data = 16'h0000;

   vga_text_writer dut (
      .clk        (clk),
      .reset      (reset),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_attr  (char_attr),
      .char_ready (char_ready),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata)
   );

   always #5 clk = ~clk;

   // Count every write; during a clear, compare against a linear blank sequence.
   always @(negedge clk) begin
      if (mem_we) begin
         if (seq_en && (mem_addr != 15'(wr_total - seq_base) || mem_wdata != seq_data || !busy))
            seq_err = seq_err + 1;
         wr_total = wr_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      char_valid = 1'b1;
      char_data  = d;
      char_attr  = a;
      tick();
      char_valid = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap, err0, n;

      // Reset state
      tick(); tick();
      chk("rst_ready", char_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_cursor", {cursor_row, cursor_col}, 0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", char_ready, 1);

      // Single printable 'A'
      snap = wr_total;
      send(8'h41, 8'h1F);
      chk("A_we", mem_we, 1);
      chk("A_addr", mem_addr, 0);
      chk("A_wdata", mem_wdata, 16'h1F41);
      chk("A_col", cursor_col, 1);
      chk("A_row", cursor_row, 0);
      tick(); tick();
      chk("A_single_write", wr_total - snap, 1);
      chk("A_we_low", mem_we, 0);

      // 80 back-to-back printables from (0,0)
      send(8'h0D, 8'h00);
      chk("cr_col", cursor_col, 0);
      snap = wr_total;
      char_valid = 1'b1;
      char_attr  = 8'h07;
      for (int i = 0; i < 80; i++) begin
         char_data = 8'h20 + 8'(i % 64);
         chk("burst_ready", char_ready, 1);
         tick();
         chk("burst_we", mem_we, 1);
         chk("burst_addr", mem_addr, i);
      end
      char_valid = 1'b0;
      chk("burst_col", cursor_col, 0);
      chk("burst_row", cursor_row, 1);
      tick(); tick();
      chk("burst_count", wr_total - snap, 80);

      // Newline: row change without a write
      snap = wr_total;
      send(8'h0A, 8'h00);
      chk("nl_row", cursor_row, 2);
      tick();
      chk("nl_no_write", wr_total - snap, 0);

      // Walk to (79,59), then wrap with 'Z'
      for (int i = 0; i < 57; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < 79; i++) send(8'h2E, 8'h07);
      chk("corner_col", cursor_col, 79);
      chk("corner_row", cursor_row, 59);
      send(8'h5A, 8'h4E);
      chk("Z_addr", mem_addr, 4799);
      chk("Z_wdata", mem_wdata, 16'h4E5A);
      chk("Z_wrap", {cursor_row, cursor_col}, 0);

      // Backspace at (5,2)
      send(8'h0A, 8'h00);
      send(8'h0A, 8'h00);
      for (int i = 0; i < 5; i++) send(8'h61, 8'h07);
      chk("pre_bs_col", cursor_col, 5);
      send(8'h08, 8'h07);
      chk("bs_we", mem_we, 1);
      chk("bs_addr", mem_addr, 164);
      chk("bs_wdata", mem_wdata, 16'h0720);
      chk("bs_col", cursor_col, 4);
      chk("bs_row", cursor_row, 2);
      send(8'h0D, 8'h00);
      tick();
      snap = wr_total;
      send(8'h08, 8'h07);
      chk("bs0_we", mem_we, 0);
      chk("bs0_cursor", {cursor_row, cursor_col}, {6'd2, 7'd0});
      tick();
      chk("bs0_no_write", wr_total - snap, 0);

      // Form feed: full screen clear
      tick();
      seq_base = wr_total;
      seq_data = 16'h0020;
      err0     = seq_err;
      seq_en   = 1'b1;
      send(8'h0C, 8'h00);
      chk("ff_busy", busy, 1);
      chk("ff_ready", char_ready, 0);
      chk("ff_cursor", {cursor_row, cursor_col}, 0);
      chk("ff_first_addr", mem_addr, 0);
      chk("ff_first_wdata", mem_wdata, 16'h0020);
      n = 0;
      while (!char_ready && n < 6000) begin
         tick();
         n = n + 1;
      end
      seq_en = 1'b0;
      chk("ff_ready_latency", n, 4800);
      chk("ff_write_count", wr_total - seq_base, 4800);
      chk("ff_seq_errors", seq_err - err0, 0);
      chk("ff_busy_end", busy, 0);
      chk("ff_we_end", mem_we, 0);
      chk("ff_last_addr", mem_addr, 4799);

      // Reset 100 cycles into a form-feed clear
      send(8'h51, 8'h11);
      send(8'h0C, 8'h22);
      for (int i = 0; i < 99; i++) tick();
      chk("mid_ff_addr", mem_addr, 99);
      chk("mid_ff_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("arst_we", mem_we, 0);
      chk("arst_addr", mem_addr, 0);
      chk("arst_wdata", mem_wdata, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", char_ready, 0);
      chk("arst_cursor", {cursor_row, cursor_col}, 0);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("post_rst_ready", char_ready, 1);
      send(8'h42, 8'h33);
      chk("B_we", mem_we, 1);
      chk("B_addr", mem_addr, 0);
      chk("B_wdata", mem_wdata, 16'h3342);
      chk("B_cursor", {cursor_row, cursor_col}, {6'd0, 7'd1});
      tick();
      chk("B_ready", char_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
